// File: rtl/adder_pkg.sv
// Shared constants and the stage-entry layout for the pipelined adder.
package adder_pkg;

    localparam int CHUNK_DEFAULT  = 4;
    localparam int WIDTH_DEFAULT  = 16;
    localparam int STAGES_DEFAULT = WIDTH_DEFAULT / CHUNK_DEFAULT;

    // One pipeline slot: operands still waiting for their slice, the result
    // slices already produced, and the carry handed to the next stage.
    typedef struct packed {
        logic                     valid;
        logic [WIDTH_DEFAULT-1:0] a;
        logic [WIDTH_DEFAULT-1:0] b_eff;
        logic [WIDTH_DEFAULT-1:0] psum;
        logic                     carry;
    } stage_entry_t;

endpackage

// File: rtl/pipe_adder_if.sv
// Handshake and data bundle between an operand producer and the adder.
interface pipe_adder_if
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Producer/consumer side: presents operands, accepts results.
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/pipe_adder_add_chunk.sv
// Combinational CHUNK-bit adder slice; also exposes the carry into its top bit.
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] full;

    assign full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum   = full[CHUNK-1:0];
    assign cout  = full[CHUNK];
    // The top sum bit is a ^ b ^ carry_in at that position, so the carry
    // into the MSB falls out without a second adder.
    assign c_msb = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract, one CHUNK-bit slice per stage, with a
// single global advance so the whole pipe moves or holds together.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CHUNK = CHUNK_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    pipe_adder_if.slave  bus
);

    localparam int STAGES = WIDTH / CHUNK;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b_eff;
        logic [WIDTH-1:0] psum;
        logic             carry;
    } entry_t;

    entry_t           stage_reg [STAGES];
    logic             out_valid_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic [CHUNK-1:0] chunk_sum  [STAGES];
    logic             chunk_cout [STAGES];
    logic             chunk_cmsb [STAGES];

    logic adv;
    logic in_ready;

    assign adv      = !out_valid_reg || bus.out_ready;
    assign in_ready = adv && !rst;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
    assign bus.ovf       = ovf_reg;

    // Stage gi adds slice gi of the operands held in stage_reg[gi].
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            add_chunk #(.CHUNK(CHUNK)) u_add (
                .a     (stage_reg[gi].a[gi*CHUNK +: CHUNK]),
                .b     (stage_reg[gi].b_eff[gi*CHUNK +: CHUNK]),
                .cin   (stage_reg[gi].carry),
                .sum   (chunk_sum[gi]),
                .cout  (chunk_cout[gi]),
                .c_msb (chunk_cmsb[gi])
            );
        end
    endgenerate

    // Shift every slot one stage on advance; results update only for valid entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_reg[k] <= '0;
            end
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else if (adv) begin
            // Subtraction is a + ~b + 1, so invert b and force the first carry.
            stage_reg[0].valid <= bus.in_valid && in_ready;
            stage_reg[0].a     <= bus.a;
            stage_reg[0].b_eff <= bus.sub ? ~bus.b : bus.b;
            stage_reg[0].psum  <= '0;
            stage_reg[0].carry <= bus.sub ? 1'b1 : bus.cin;

            for (int k = 1; k < STAGES; k++) begin
                stage_reg[k]                              <= stage_reg[k-1];
                stage_reg[k].psum[(k-1)*CHUNK +: CHUNK]   <= chunk_sum[k-1];
                stage_reg[k].carry                        <= chunk_cout[k-1];
            end

            out_valid_reg <= stage_reg[STAGES-1].valid;
            if (stage_reg[STAGES-1].valid) begin
                sum_reg                        <= stage_reg[STAGES-1].psum;
                sum_reg[WIDTH-CHUNK +: CHUNK]  <= chunk_sum[STAGES-1];
                cout_reg                       <= chunk_cout[STAGES-1];
                ovf_reg                        <= chunk_cmsb[STAGES-1] ^ chunk_cout[STAGES-1];
            end
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Randomised bench for pipe_adder (WIDTH=16, CHUNK=4) with a queue-based model.
module tb_pipe_adder;

    localparam int W   = 16;
    localparam int STG = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(W)) bus ();

    pipe_adder #(.WIDTH(W), .CHUNK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cnt;
    } exp_t;

    exp_t         q[$];
    bit           live = 1'b0;
    logic [W-1:0] last_sum  = '0;
    logic         last_cout = 1'b0;
    logic         last_ovf  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: plain modular add, overflow from operand/result signs.
    function automatic exp_t golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic cin, input logic sub);
        exp_t         r;
        logic [W-1:0] beff;
        logic [W:0]   full;
        beff   = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, beff} + (W+1)'(sub ? 1'b1 : cin);
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (a[W-1] == beff[W-1]) && (full[W-1] != a[W-1]);
        r.cnt  = 0;
        return r;
    endfunction

    function automatic bit model_out_valid();
        return (q.size() > 0) && (q[0].cnt >= STG);
    endfunction

    // Model update on each edge: consume, age in-flight entries, accept.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            last_sum  = '0;
            last_cout = 1'b0;
            last_ovf  = 1'b0;
            live      = 1'b1;
        end else if (live) begin
            bit ov;
            bit adv;
            ov  = model_out_valid();
            adv = !ov || bus.out_ready;
            if (ov && bus.out_ready) void'(q.pop_front());
            if (adv) begin
                foreach (q[i]) q[i].cnt++;
                if (bus.in_valid) q.push_back(golden(bus.a, bus.b, bus.cin, bus.sub));
            end
        end
    end

    // Compare process: outputs against the model between edges.
    always @(negedge clk) begin
        if (live) begin
            bit ov;
            ov = model_out_valid();
            check("out_valid", bus.out_valid, ov);
            check("in_ready", bus.in_ready, !rst && (!ov || bus.out_ready));
            if (ov) begin
                last_sum  = q[0].sum;
                last_cout = q[0].cout;
                last_ovf  = q[0].ovf;
            end
            check("sum", bus.sum, last_sum);
            check("cout", bus.cout, last_cout);
            check("ovf", bus.ovf, last_ovf);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation with literal expectations and latency measurement.
    task automatic dir_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input logic [W-1:0] e_sum,
                          input logic e_cout, input logic e_ovf);
        int lat;
        bit found;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check({name, "_accept"}, bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.cin      = 1'($urandom);
        bus.sub      = 1'($urandom);
        lat   = 0;
        found = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) begin
                found = 1'b1;
                lat   = i;
                check({name, "_sum"}, bus.sum, e_sum);
                check({name, "_cout"}, bus.cout, e_cout);
                check({name, "_ovf"}, bus.ovf, e_ovf);
            end
        end
        check({name, "_found"}, found, 1'b1);
        check({name, "_latency"}, lat, STG);
        $display("[TB] op %s a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
                 name, a, b, cin, sub, bus.sum, bus.cout, bus.ovf, lat);
        tick();
    endtask

    // Stream n operations; fixed stall window or random valid/ready.
    task automatic stream(input string name, input int n, input int stall_start,
                          input int stall_len, input bit rand_mode);
        int  sent = 0;
        int  cyc  = 0;
        bit  need_new = 1'b1;
        bit  acc;
        while (sent < n && cyc < 5000) begin
            if (need_new) begin
                bus.a        = W'($urandom);
                bus.b        = W'($urandom);
                bus.cin      = 1'($urandom);
                bus.sub      = 1'($urandom);
                bus.in_valid = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            bus.out_ready = rand_mode ? ($urandom_range(0, 3) != 0)
                                      : !(cyc >= stall_start && cyc < stall_start + stall_len);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (acc) $display("[TB] %s accept #%0d a=%h b=%h cin=%0d sub=%0d",
                              name, sent, bus.a, bus.b, bus.cin, bus.sub);
            tick();
            cyc++;
            if (acc) sent++;
            need_new = acc || !bus.in_valid;
        end
        check({name, "_all_sent"}, sent, n);
        if (!rand_mode) check({name, "_cycles"}, cyc, n + stall_len);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && q.size() != 0; i++) tick();
        check({name, "_drained"}, q.size(), 0);
    endtask

    initial begin
        exp_t g;
        int   ov_seen;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        // Pin the reference arithmetic to hand-computed values.
        g = golden(16'h1234, 16'h0FCD, 1'b1, 1'b0);
        check("model_add", {g.ovf, g.cout, g.sum}, {1'b0, 1'b0, 16'h2202});
        g = golden(16'h8000, 16'h0001, 1'b0, 1'b1);
        check("model_sub", {g.ovf, g.cout, g.sum}, {1'b1, 1'b1, 16'h7FFF});
        g = golden(16'h0003, 16'h0005, 1'b1, 1'b1);
        check("model_sub_neg", {g.ovf, g.cout, g.sum}, {1'b0, 1'b0, 16'hFFFE});

        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_sum", bus.sum, 16'h0000);
        check("rst_cout", bus.cout, 1'b0);
        check("rst_ovf", bus.ovf, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        tick();

        dir_op("add",      16'h1234, 16'h0FCD, 1'b1, 1'b0, 16'h2202, 1'b0, 1'b0);
        dir_op("ripple",   16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        dir_op("ovf_add",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        dir_op("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        dir_op("sub_neg",  16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        stream("stall", 8, 6, 3, 1'b0);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            bus.a        = W'($urandom);
            bus.b        = W'($urandom);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ov_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) ov_seen++;
            tick();
        end
        check("flush_no_output", ov_seen, 0);
        dir_op("post_rst", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

        stream("random", 200, 0, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined successor to the 4-bit ripple-carry adder. It adds or subtracts two WIDTH-bit operands in CHUNK-bit slices, one slice per pipeline stage, with the carry registered between stages. Throughput is one operation per cycle, with valid/ready handshakes on both sides. It sits in the datapath wherever a wide add would break timing as a single ripple chain.

## Interface
Parameters:
- WIDTH, 16, operand and result width; must be a multiple of CHUNK
- CHUNK, 4, bits added per stage
- STAGES (localparam), WIDTH/CHUNK, pipeline depth and latency in cycles

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, synchronous and active-high
- in_valid  input  1  operand set presented
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add mode only)
- sub  input  1  0: a+b+cin; 1: a-b (cin ignored)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  raw carry out of MSB (in sub mode, 1 means no borrow)
- ovf  output  1  signed overflow, equal to carry into MSB XOR cout

## Operation
- Operand B is transformed as b_eff = sub ? ~b : b, and the initial carry as c0 = sub ? 1 : cin. Both are captured at accept.
- Stage k (k = 0..STAGES-1) adds slice k of a and b_eff plus the carry registered from stage k-1 (stage 0 uses c0).
- Skew: slices above k travel through the stage registers unused until their stage.
- Deskew: result slices below k travel through the stage registers until the output.
- The last stage also produces the carry into the MSB, which is needed for ovf.
- Each stage carries a valid bit.
- Global advance: adv = !out_valid || out_ready. When adv is high every stage shifts by one, and bubbles shift as invalid entries. When adv is low, everything holds.
- in_ready = adv && !rst. An operand set is accepted on in_valid && in_ready.
- Arithmetic is modulo 2^WIDTH. No saturation.
- sum, cout and ovf change only when a valid entry reaches the output. They hold their value otherwise, including while out_valid=0.
- Results leave in acceptance order. None are dropped or duplicated.

## Timing
- Reset (rst high at a clock edge) clears every stage valid bit and data register. The cycle after reset: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
- in_ready=0 whenever rst is high.
- Latency: an operand set accepted at edge n produces out_valid=1 after edge n+STAGES, provided no stall occurred.
- Each stall cycle (out_valid && !out_ready) adds one cycle of latency to every in-flight entry.
- Stall: sum, cout, ovf and out_valid are held stable. in_ready=0.
- Simultaneous output handshake and input accept in the same cycle is legal. It sustains full throughput.
- Reset mid-operation: all in-flight entries are discarded, and no result emerges for them.
- sub or cin changing while in_valid is low has no effect.

## Structure
- Package adder_pkg: stage-entry typedef (valid, a/b_eff remaining slices, partial sum, carry) parametrised via the localparams, plus a CHUNK default constant.
- Sub-module add_chunk: combinational CHUNK-bit adder. Inputs: a, b, cin. Outputs: sum, cout, and c_msb (carry into the top bit). Instantiated once per stage through a generate loop.
- Optional SV interface bundling the handshake and data signals, with modports for the producer and consumer sides.

## Test plan
All scenarios use WIDTH=16, CHUNK=4, so latency is 4.
- Reset: hold rst for 2 cycles, then release. Next cycle: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
- Single add: a=16'h1234, b=16'h0FCD, cin=1, sub=0. Four cycles later: sum=16'h2202, cout=0, ovf=0, with out_valid high for exactly one cycle while out_ready=1.
- Full carry ripple: a=16'hFFFF, b=16'h0000, cin=1 gives sum=16'h0000, cout=1, ovf=0. Also a=16'h7FFF, b=16'h0001, cin=0 gives sum=16'h8000, cout=0, ovf=1.
- Subtract: a=16'h8000, b=16'h0001, sub=1 gives sum=16'h7FFF, cout=1, ovf=1. Also a=16'h0003, b=16'h0005, sub=1 gives sum=16'hFFFE, cout=0, ovf=0.
- Streaming with backpressure: 8 back-to-back random operations, with out_ready=0 for 3 cycles starting at cycle 6. Required: in_ready=0 and outputs stable during the stall, all 8 results correct and in order, and throughput returns to 1 per cycle afterwards.
- Reset mid-flight: accept 3 operations, assert rst on the next cycle. No out_valid follows, and the next new operation emerges 4 cycles after its accept with the correct value.
